// File: rtl/pcie_os_pkg.sv
// Shared ordered-set symbol constants and lane FSM encoding for the RX ordered-set path.
package pcie_os_pkg;

  localparam logic [7:0] COM       = 8'hBC;
  localparam logic [7:0] TS1_ID    = 8'h4A;
  localparam logic [7:0] TS2_ID    = 8'h45;
  localparam logic [7:0] GEN3_TS1  = 8'h1E;
  localparam logic [7:0] GEN3_TS2  = 8'h2D;
  localparam logic [1:0] SYNC_OS   = 2'b01;
  localparam logic [1:0] SYNC_DATA = 2'b10;

  typedef enum logic [1:0] {
    LANE_HUNT    = 2'd0,
    LANE_COLLECT = 2'd1,
    LANE_DONE    = 2'd2
  } laneState_e;

  // 8b/10b TS identifier carried in symbols 6..15
  function automatic logic isTsId(input logic [7:0] s);
    return (s == TS1_ID) || (s == TS2_ID);
  endfunction

  // 128b/130b ordered-set identifier carried in symbol 0
  function automatic logic isGen3TsId(input logic [7:0] s);
    return (s == GEN3_TS1) || (s == GEN3_TS2);
  endfunction

endpackage

// File: rtl/os_lane_assembler.sv
// One lane slice: hunts for a TS1/TS2 start and assembles its 16 symbols into osWord.
module os_lane_assembler
  import pcie_os_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   Gen,
  input  logic [7:0]   rxData,
  input  logic         rxDataK,
  input  logic         rxStartBlock,
  input  logic [1:0]   rxSyncHeader,
  input  logic         rxValid,
  input  logic         clear,
  output logic         done,
  output logic [127:0] osWord
);

  laneState_e       state, stateNext;
  logic [3:0]       idx, idxNext, wrIdx;
  logic [15:0][7:0] word;
  logic             wrEn, abort, restart;
  logic             isGen3, isCom, gen3Start;

  // Any rate other than 3 follows the 8b/10b symbol rules.
  assign isGen3    = (Gen == 3'd3);
  assign isCom     = rxDataK && (rxData == COM);
  assign gen3Start = rxStartBlock && (rxSyncHeader == SYNC_OS) && isGen3TsId(rxData);

  // Lane state register
  always_ff @(posedge clk) begin
    if (reset) state <= LANE_HUNT;
    else       state <= stateNext;
  end

  // Next state plus the index/write decision for the symbol on the wire
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    wrEn      = 1'b0;
    wrIdx     = idx;
    abort     = 1'b0;
    restart   = 1'b0;
    if (clear) begin
      stateNext = LANE_HUNT;
      idxNext   = '0;
    end else if (rxValid) begin
      unique case (state)
        LANE_HUNT: begin
          if (isGen3 ? gen3Start : isCom) begin
            stateNext = LANE_COLLECT;
            idxNext   = 4'd1;
            wrEn      = 1'b1;
            wrIdx     = 4'd0;
          end
        end
        LANE_COLLECT: begin
          if (isGen3)               abort   = rxStartBlock;
          else if (isCom)           restart = 1'b1;
          else if (rxDataK)         abort   = 1'b1;
          else if (idx == 4'd6)     abort   = !isTsId(rxData);
          else if (idx > 4'd6)      abort   = (rxData != word[6]);
          if (restart) begin
            // A fresh COM mid-set means the previous capture was a fragment.
            idxNext = 4'd1;
            wrEn    = 1'b1;
            wrIdx   = 4'd0;
          end else if (abort) begin
            stateNext = LANE_HUNT;
            idxNext   = '0;
          end else begin
            wrEn = 1'b1;
            if (idx == 4'd15) begin
              stateNext = LANE_DONE;
              idxNext   = '0;
            end else begin
              idxNext = idx + 4'd1;
            end
          end
        end
        default: ; // DONE holds until the top clears the lane
      endcase
    end
  end

  // Symbol storage and index
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      word <= '0;
    end else begin
      idx <= idxNext;
      if (wrEn) word[wrIdx] <= rxData;
    end
  end

  // Status outputs
  always_comb begin
    done   = (state == LANE_DONE);
    osWord = word;
  end

endmodule

// File: rtl/rx_os_collector.sv
// Collects one TS1/TS2 per active lane and publishes all lanes together, with coarse deskew timeout.
module rx_os_collector
  import pcie_os_pkg::*;
#(
  parameter int LANES         = 16,
  parameter int DESKEW_CYCLES = 8
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           Gen,
  input  logic [4:0]           numberOfDetectedLanes,
  input  logic [LANES*8-1:0]   rxData,
  input  logic [LANES-1:0]     rxDataK,
  input  logic [LANES-1:0]     rxStartBlock,
  input  logic [LANES*2-1:0]   rxSyncHeader,
  input  logic [LANES-1:0]     rxValid,
  output logic [LANES*128-1:0] orderedSets,
  output logic                 validOrderedSets
);

  localparam int CNT_W = $clog2(DESKEW_CYCLES + 1);

  logic [LANES-1:0]        doneMask, activeMask, laneClear;
  logic [LANES-1:0][127:0] laneWord, pubWord;
  logic [CNT_W-1:0]        deskewCnt;
  logic [2:0]              genQ;
  logic                    publish, discard, anyDone, genChange;

  for (genvar g = 0; g < LANES; g++) begin : gLane
    os_lane_assembler uLane (
      .clk          (clk),
      .reset        (reset),
      .Gen          (Gen),
      .rxData       (rxData[8*g +: 8]),
      .rxDataK      (rxDataK[g]),
      .rxStartBlock (rxStartBlock[g]),
      .rxSyncHeader (rxSyncHeader[2*g +: 2]),
      .rxValid      (rxValid[g]),
      .clear        (laneClear[g]),
      .done         (doneMask[g]),
      .osWord       (laneWord[g])
    );
  end

  // Active lanes are 0..n-1; counts beyond LANES naturally select every lane.
  always_comb begin
    activeMask = '0;
    for (int i = 0; i < LANES; i++) activeMask[i] = (i < int'(numberOfDetectedLanes));
  end

  assign genChange = (Gen != genQ);
  assign publish   = (activeMask != '0) && ((doneMask & activeMask) == activeMask);
  assign anyDone   = |(doneMask & activeMask);
  // Publish beats a timeout landing on the same cycle.
  assign discard   = anyDone && !publish && (deskewCnt == CNT_W'(DESKEW_CYCLES));
  assign laneClear = {LANES{publish | discard | genChange}} | ~activeMask;

  // Inactive slots publish as zero
  always_comb begin
    pubWord = '0;
    for (int i = 0; i < LANES; i++) pubWord[i] = activeMask[i] ? laneWord[i] : 128'h0;
  end

  // Previous rate for change detection; only its difference from Gen matters
  always_ff @(posedge clk) begin
    genQ <= Gen;
  end

  // Deskew window: counts from the first active lane done until publish or timeout
  always_ff @(posedge clk) begin
    if (reset)                                          deskewCnt <= '0;
    else if (genChange || publish || discard || !anyDone) deskewCnt <= '0;
    else                                                deskewCnt <= deskewCnt + 1'b1;
  end

  // Output registers and publish strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      orderedSets      <= '0;
      validOrderedSets <= 1'b0;
    end else begin
      validOrderedSets <= publish;
      if (publish) orderedSets <= pubWord;
    end
  end

endmodule

// File: tb/tb_rx_os_collector.sv
// Bench for rx_os_collector: per-cycle stimulus tables, expected words built from TS layout rules.
module tb_rx_os_collector;

  localparam int LANES = 16;
  localparam int MAXC  = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       sb;
    logic [1:0] sh;
    logic       v;
  } sym_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [2:0]           Gen = 3'd1;
  logic [4:0]           numberOfDetectedLanes = 5'd4;
  logic [LANES*8-1:0]   rxData = '0;
  logic [LANES-1:0]     rxDataK = '0, rxStartBlock = '0, rxValid = '0;
  logic [LANES*2-1:0]   rxSyncHeader = '0;
  logic [LANES*128-1:0] orderedSets;
  logic                 validOrderedSets;

  always #5 clk = ~clk;

  rx_os_collector #(.LANES(LANES), .DESKEW_CYCLES(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .Gen                   (Gen),
    .numberOfDetectedLanes (numberOfDetectedLanes),
    .rxData                (rxData),
    .rxDataK               (rxDataK),
    .rxStartBlock          (rxStartBlock),
    .rxSyncHeader          (rxSyncHeader),
    .rxValid               (rxValid),
    .orderedSets           (orderedSets),
    .validOrderedSets      (validOrderedSets)
  );

  sym_t                 stim [MAXC][LANES];
  logic [127:0]         expW [LANES];
  logic [127:0]         prevW [LANES];
  logic [127:0]         junk;
  logic [LANES*128-1:0] pubSets = '0;
  int                   vectors = 0, miscompares = 0, nPulse = 0, pulseAt = -1;

  task automatic clearStim();
    for (int c = 0; c < MAXC; c++)
      for (int l = 0; l < LANES; l++)
        stim[c][l] = '{d: 8'h00, k: 1'b0, sb: 1'b0, sh: 2'b00, v: 1'b1};
  endtask

  // 8b/10b TS: COM, link 0, lane, 3 random, 10 x ID; optional rxValid-low gap before symbol stallAt
  task automatic putTs12(input int lane, input int start, input bit ts2,
                         input int stallAt, input int stallLen, output logic [127:0] w);
    logic [7:0] s;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0)      s = 8'hBC;
      else if (k == 1) s = 8'h00;
      else if (k == 2) s = 8'(lane);
      else if (k < 6)  s = 8'($urandom);
      else             s = ts2 ? 8'h45 : 8'h4A;
      stim[start + k + ((k >= stallAt) ? stallLen : 0)][lane] = '{d: s, k: (k == 0), sb: 1'b0, sh: 2'b00, v: 1'b1};
      w[8*k +: 8] = s;
    end
    for (int j = 0; j < stallLen; j++)
      stim[start + stallAt + j][lane] = '{d: 8'hBC, k: 1'b1, sb: 1'b1, sh: 2'b01, v: 1'b0};
  endtask

  // 130b block: symbol 0 with start-of-block and given header, 15 random payload symbols
  task automatic putTs3(input int lane, input int start, input logic [7:0] sym0,
                        input logic [1:0] sh, output logic [127:0] w);
    logic [7:0] s;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      s = (k == 0) ? sym0 : 8'($urandom);
      stim[start + k][lane] = '{d: s, k: 1'b0, sb: (k == 0), sh: (k == 0) ? sh : 2'b00, v: 1'b1};
      w[8*k +: 8] = s;
    end
  endtask

  task automatic run(input int from, input int to);
    for (int c = from; c < to; c++) begin
      @(negedge clk);
      for (int l = 0; l < LANES; l++) begin
        rxData[8*l +: 8]       = stim[c][l].d;
        rxDataK[l]             = stim[c][l].k;
        rxStartBlock[l]        = stim[c][l].sb;
        rxSyncHeader[2*l +: 2] = stim[c][l].sh;
        rxValid[l]             = stim[c][l].v;
      end
      @(posedge clk); #1;
      if (validOrderedSets) begin
        nPulse++;
        pulseAt = c + 1;
        pubSets = orderedSets;
      end
    end
  endtask

  task automatic test_reset();
    clearStim();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (validOrderedSets !== 1'b0) begin miscompares++; $display("FAIL reset.valid got %b want 0", validOrderedSets); end
    vectors++;
    if (orderedSets !== '0) begin miscompares++; $display("FAIL reset.sets got nonzero want 0"); end
    reset = 1'b0;
    nPulse = 0;
    run(0, 6);
    vectors++;
    if (nPulse !== 0) begin miscompares++; $display("FAIL reset.idle pulses got %0d want 0", nPulse); end
  endtask

  task automatic test_gen1_aligned();
    logic [127:0] want;
    Gen = 3'd1; numberOfDetectedLanes = 5'd4;
    clearStim();
    for (int l = 0; l < 4; l++) putTs12(l, 2, 1'b0, 16, 0, expW[l]);
    nPulse = 0; run(0, 25);
    vectors++;
    if (nPulse !== 1) begin miscompares++; $display("FAIL aligned.pulses got %0d want 1", nPulse); end
    vectors++;
    if (pulseAt !== 19) begin miscompares++; $display("FAIL aligned.cycle got %0d want 19", pulseAt); end
    for (int i = 0; i < LANES; i++) begin
      want = (i < 4) ? expW[i] : 128'h0;
      vectors++;
      if (pubSets[128*i +: 128] !== want) begin
        miscompares++; $display("FAIL aligned.slot%0d got %h want %h", i, pubSets[128*i +: 128], want);
      end
    end
  endtask

  task automatic test_gen1_skew();
    clearStim();
    for (int l = 0; l < 4; l++) putTs12(l, (l == 3) ? 7 : 2, 1'b0, 16, 0, expW[l]);
    nPulse = 0; run(0, 30);
    vectors++;
    if (nPulse !== 1) begin miscompares++; $display("FAIL skew5.pulses got %0d want 1", nPulse); end
    vectors++;
    if (pulseAt !== 24) begin miscompares++; $display("FAIL skew5.cycle got %0d want 24", pulseAt); end
    vectors++;
    if (pubSets[128*3 +: 128] !== expW[3]) begin
      miscompares++; $display("FAIL skew5.slot3 got %h want %h", pubSets[128*3 +: 128], expW[3]);
    end
    prevW = expW;
    clearStim();
    for (int l = 0; l < 4; l++) putTs12(l, (l == 3) ? 11 : 2, 1'b1, 16, 0, expW[l]);
    nPulse = 0; run(0, 35);
    vectors++;
    if (nPulse !== 0) begin miscompares++; $display("FAIL skew9.pulses got %0d want 0", nPulse); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (orderedSets[128*i +: 128] !== prevW[i]) begin
        miscompares++; $display("FAIL skew9.hold%0d got %h want %h", i, orderedSets[128*i +: 128], prevW[i]);
      end
    end
  endtask

  task automatic test_gen2_corrupt();
    Gen = 3'd2; numberOfDetectedLanes = 5'd4;
    clearStim();
    for (int l = 0; l < 4; l++) putTs12(l, 2, 1'b0, 16, 0, junk);
    stim[12][0].d = 8'h45;
    for (int l = 0; l < 4; l++) putTs12(l, 30, 1'b0, 16, 0, expW[l]);
    nPulse = 0; run(0, 55);
    vectors++;
    if (nPulse !== 1) begin miscompares++; $display("FAIL corrupt.pulses got %0d want 1", nPulse); end
    vectors++;
    if (pulseAt !== 47) begin miscompares++; $display("FAIL corrupt.cycle got %0d want 47", pulseAt); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pubSets[128*i +: 128] !== expW[i]) begin
        miscompares++; $display("FAIL corrupt.slot%0d got %h want %h", i, pubSets[128*i +: 128], expW[i]);
      end
    end
  endtask

  task automatic test_com_restart();
    Gen = 3'd1; numberOfDetectedLanes = 5'd4;
    clearStim();
    putTs12(0, 2, 1'b0, 16, 0, junk);
    for (int l = 0; l < 4; l++) putTs12(l, 9, 1'b0, 16, 0, expW[l]);
    nPulse = 0; run(0, 32);
    vectors++;
    if (nPulse !== 1) begin miscompares++; $display("FAIL comidx7.pulses got %0d want 1", nPulse); end
    vectors++;
    if (pulseAt !== 26) begin miscompares++; $display("FAIL comidx7.cycle got %0d want 26", pulseAt); end
    vectors++;
    if (pubSets[7:0] !== 8'hBC) begin miscompares++; $display("FAIL comidx7.sym0 got %h want bc", pubSets[7:0]); end
    vectors++;
    if (pubSets[127:0] !== expW[0]) begin
      miscompares++; $display("FAIL comidx7.slot0 got %h want %h", pubSets[127:0], expW[0]);
    end
  endtask

  task automatic test_gen3();
    logic [127:0] want;
    Gen = 3'd3; numberOfDetectedLanes = 5'd8;
    clearStim();
    for (int l = 0; l < 8; l++) begin
      if (l < 4) putTs3(l, 2, 8'h2D, 2'b10, junk);
      else       putTs3(l, 2, 8'hAA, 2'b01, junk);
      putTs3(l, 18, 8'h2D, 2'b01, expW[l]);
    end
    nPulse = 0; run(0, 40);
    vectors++;
    if (nPulse !== 1) begin miscompares++; $display("FAIL gen3.pulses got %0d want 1", nPulse); end
    vectors++;
    if (pulseAt !== 35) begin miscompares++; $display("FAIL gen3.cycle got %0d want 35", pulseAt); end
    for (int i = 0; i < LANES; i++) begin
      want = (i < 8) ? expW[i] : 128'h0;
      vectors++;
      if (pubSets[128*i +: 128] !== want) begin
        miscompares++; $display("FAIL gen3.slot%0d got %h want %h", i, pubSets[128*i +: 128], want);
      end
    end
  endtask

  task automatic test_stall();
    Gen = 3'd1; numberOfDetectedLanes = 5'd4;
    clearStim();
    for (int l = 0; l < 4; l++) putTs12(l, 2, 1'b1, (l == 1) ? 8 : 16, (l == 1) ? 3 : 0, expW[l]);
    nPulse = 0; run(0, 28);
    vectors++;
    if (nPulse !== 1) begin miscompares++; $display("FAIL stall.pulses got %0d want 1", nPulse); end
    vectors++;
    if (pulseAt !== 22) begin miscompares++; $display("FAIL stall.cycle got %0d want 22", pulseAt); end
    vectors++;
    if (pubSets[128*1 +: 128] !== expW[1]) begin
      miscompares++; $display("FAIL stall.slot1 got %h want %h", pubSets[128*1 +: 128], expW[1]);
    end
  endtask

  task automatic test_reset_mid();
    Gen = 3'd1; numberOfDetectedLanes = 5'd4;
    clearStim();
    for (int l = 0; l < 4; l++) putTs12(l, 2, 1'b0, 16, 0, junk);
    nPulse = 0; run(0, 11);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (orderedSets !== '0) begin miscompares++; $display("FAIL resetmid.sets got nonzero want 0"); end
    vectors++;
    if (validOrderedSets !== 1'b0) begin miscompares++; $display("FAIL resetmid.valid got %b want 0", validOrderedSets); end
    @(negedge clk); reset = 1'b0;
    for (int l = 0; l < 4; l++) putTs12(l, 25, 1'b0, 16, 0, expW[l]);
    run(12, 45);
    vectors++;
    if (nPulse !== 1) begin miscompares++; $display("FAIL resetmid.pulses got %0d want 1", nPulse); end
    vectors++;
    if (pulseAt !== 42) begin miscompares++; $display("FAIL resetmid.cycle got %0d want 42", pulseAt); end
    vectors++;
    if (pubSets[128*2 +: 128] !== expW[2]) begin
      miscompares++; $display("FAIL resetmid.slot2 got %h want %h", pubSets[128*2 +: 128], expW[2]);
    end
  endtask

  // Random rate, lane count and skew; publish expected iff lanes exist and skew stays within 8
  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int n, nAct, g, maxSkew, st, lo, hi;
      bit expPub;
      logic [127:0] want;
      g = int'($urandom_range(1, 3));
      n = int'($urandom_range(0, 20));
      maxSkew = int'($urandom_range(0, 10));
      nAct = (n > 16) ? 16 : n;
      Gen = 3'(g); numberOfDetectedLanes = 5'(n);
      clearStim();
      lo = 99; hi = 0;
      for (int l = 0; l < LANES; l++) begin
        if (l < nAct) begin
          st = 2 + int'($urandom_range(0, maxSkew));
          if (st < lo) lo = st;
          if (st > hi) hi = st;
          if (g == 3) putTs3(l, st, ($urandom_range(0, 1) != 0) ? 8'h2D : 8'h1E, 2'b01, expW[l]);
          else        putTs12(l, st, ($urandom_range(0, 1) != 0), 16, 0, expW[l]);
        end else begin
          for (int c = 0; c < MAXC; c++) stim[c][l] = sym_t'(13'($urandom));
        end
      end
      expPub = (nAct > 0) && (hi - lo <= 8);
      nPulse = 0; run(0, hi + 22);
      vectors++;
      if (nPulse !== (expPub ? 1 : 0)) begin
        miscompares++; $display("FAIL rand%0d.pulses got %0d want %0d (gen %0d n %0d skew %0d)", it, nPulse, expPub, g, n, hi - lo);
      end
      if (expPub) begin
        vectors++;
        if (pulseAt !== hi + 17) begin miscompares++; $display("FAIL rand%0d.cycle got %0d want %0d", it, pulseAt, hi + 17); end
        for (int i = 0; i < LANES; i++) begin
          want = (i < nAct) ? expW[i] : 128'h0;
          vectors++;
          if (pubSets[128*i +: 128] !== want) begin
            miscompares++; $display("FAIL rand%0d.slot%0d got %h want %h", it, i, pubSets[128*i +: 128], want);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_gen1_aligned();
    test_gen1_skew();
    test_gen2_corrupt();
    test_com_restart();
    test_gen3();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
